// File: rtl/trig_echo_meter.sv
// -----------------------------------------------------------------------------
// trig_echo_meter
//
// Ranging front end for the ultrasonic distance sensor. A rising edge on
// tick_in (the frequency divider's clk_out) starts one measurement cycle:
// a TRIG_CYCLES-wide trigger pulse is issued, then the width of the returned
// echo pulse is counted in clk cycles and presented with a one-cycle strobe.
//
// Optional feature (compile-time macro ECHO_AVG_EN):
//   defined   - echo_count is the truncated mean of the last 4 valid widths;
//               count_valid stays low until 4 results have been collected
//               since reset, and the strobe arrives one cycle later than the
//               raw path. Timeouts never enter the averaging window.
//   undefined - echo_count is the raw width of the latest valid echo.
//
// Parameters:
//   TRIG_CYCLES    trigger pulse width in clk cycles
//   TIMEOUT_CYCLES limit for the wait-for-echo phase and for the echo-high phase
//   CNT_W          width of echo_count and internal timers (holds TIMEOUT_CYCLES)
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   rst          synchronous reset, active-high
//   tick_in      divider output level; rising edge requests a measurement
//   echo         sensor echo, asynchronous to clk
//   trig         registered trigger pulse to the sensor
//   echo_count   last valid echo width (or 4-sample mean), held between results
//   count_valid  one-cycle strobe when echo_count updates
//   timeout      one-cycle strobe when a measurement is abandoned
//   missed_tick  one-cycle strobe when a tick edge arrives while busy
//   busy         high whenever the FSM is outside IDLE
// -----------------------------------------------------------------------------
module trig_echo_meter #(
  parameter int TRIG_CYCLES    = 250,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             echo,
  output logic             trig,
  output logic [CNT_W-1:0] echo_count,
  output logic             count_valid,
  output logic             timeout,
  output logic             missed_tick,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG    = 3'd1,
    WAIT_HI = 3'd2,
    MEASURE = 3'd3,
    RECOVER = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MEAS_MAX  = CNT_W'(TIMEOUT_CYCLES);

  // ---------------------------------------------------------------------------
  // Input synchronizers and tick edge detect
  // ---------------------------------------------------------------------------
  logic       tick_m, tick_s, tick_d, tick_rise;
  logic       echo_m, echo_s;
  logic [1:0] flush_q;
  logic       armed_q;

  // The synchronizer flops come out of reset at 0, so a tick_in level that is
  // already high would otherwise look like a fresh rising edge. Edge detection
  // is armed only after the synchronizer has flushed and tick_s has been seen
  // low, so a level held through reset needs a real fall and rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_m    <= 1'b0;
      tick_s    <= 1'b0;
      tick_d    <= 1'b0;
      tick_rise <= 1'b0;
      echo_m    <= 1'b0;
      echo_s    <= 1'b0;
      flush_q   <= 2'b00;
      armed_q   <= 1'b0;
    end else begin
      tick_m    <= tick_in;
      tick_s    <= tick_m;
      tick_d    <= tick_s;
      tick_rise <= tick_s & ~tick_d & armed_q;
      echo_m    <= echo;
      echo_s    <= echo_m;
      flush_q   <= {flush_q[0], 1'b1};
      armed_q   <= armed_q | (flush_q[1] & ~tick_s);
    end
  end

  // ---------------------------------------------------------------------------
  // Measurement FSM (state register + next-state logic)
  // ---------------------------------------------------------------------------
  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] tmr_q, tmr_nxt;
  logic             to_nxt;
  logic             res_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // One timer serves all phases: trigger width in TRIG, wait time in WAIT_HI
  // and echo width in MEASURE. Entering MEASURE loads 1 because the WAIT_HI
  // cycle that saw echo_s high is the first high sample of the echo.
  always_comb begin
    state_nxt = state_q;
    tmr_nxt   = tmr_q;
    to_nxt    = 1'b0;
    res_nxt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick_rise) begin
          state_nxt = TRIG;
          tmr_nxt   = '0;
        end
      end
      TRIG: begin
        if (tmr_q == TRIG_LAST) begin
          state_nxt = WAIT_HI;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr_q + CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (echo_s) begin
          state_nxt = MEASURE;
          tmr_nxt   = CNT_ONE;
        end else if (tmr_q == WAIT_LAST) begin
          state_nxt = IDLE;
          to_nxt    = 1'b1;
        end else begin
          tmr_nxt = tmr_q + CNT_ONE;
        end
      end
      MEASURE: begin
        if (!echo_s) begin
          state_nxt = IDLE;
          res_nxt   = 1'b1;
        end else if (tmr_q == MEAS_MAX) begin
          state_nxt = RECOVER;
          to_nxt    = 1'b1;
        end else begin
          tmr_nxt = tmr_q + CNT_ONE;
        end
      end
      RECOVER: begin
        // Hold off until the over-long echo ends so its tail is not measured.
        if (!echo_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Timer contents are only meaningful after the load on TRIG entry.
  always_ff @(posedge clk) begin
    tmr_q <= tmr_nxt;
  end

  // ---------------------------------------------------------------------------
  // Stage p0: registered control outputs and raw result
  // ---------------------------------------------------------------------------
  logic             trig_q, busy_q, timeout_q, missed_q;
  logic [CNT_W-1:0] res_cnt_p0;
  logic             vld_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q     <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      missed_q   <= 1'b0;
      vld_p0     <= 1'b0;
      res_cnt_p0 <= '0;
    end else begin
      trig_q    <= (state_nxt == TRIG);
      busy_q    <= (state_nxt != IDLE);
      timeout_q <= to_nxt;
      // A tick edge in the cycle the FSM is leaving for IDLE is still dropped.
      missed_q  <= tick_rise && (state_q != IDLE);
      vld_p0    <= res_nxt;
      if (res_nxt) begin
        res_cnt_p0 <= tmr_q;
      end
    end
  end

  assign trig        = trig_q;
  assign busy        = busy_q;
  assign timeout     = timeout_q;
  assign missed_tick = missed_q;

`ifdef ECHO_AVG_EN
  // ---------------------------------------------------------------------------
  // Stage p1: 4-sample moving average of valid widths
  // ---------------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] avg4(input logic [CNT_W+1:0] sum);
    return sum[CNT_W+1:2];
  endfunction

  logic [CNT_W-1:0] win_p1 [4];
  logic [CNT_W+1:0] sum_p1;
  logic [CNT_W+1:0] sum_nxt;
  logic [1:0]       fill_p1;
  logic [CNT_W-1:0] avg_cnt_p1;
  logic             vld_p1;

  // Running sum: add the newest width, drop the oldest. The window starts at
  // zero so the sum is always exactly the total of the four entries.
  assign sum_nxt = sum_p1 + {2'b00, res_cnt_p0} - {2'b00, win_p1[3]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        win_p1[i] <= '0;
      end
      sum_p1     <= '0;
      fill_p1    <= 2'd0;
      avg_cnt_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (vld_p0) begin
        win_p1[0] <= res_cnt_p0;
        win_p1[1] <= win_p1[0];
        win_p1[2] <= win_p1[1];
        win_p1[3] <= win_p1[2];
        sum_p1    <= sum_nxt;
        // fill_p1 saturates at 3: three earlier results plus this one is a full window.
        if (fill_p1 == 2'd3) begin
          avg_cnt_p1 <= avg4(sum_nxt);
          vld_p1     <= 1'b1;
        end else begin
          fill_p1 <= fill_p1 + 2'd1;
        end
      end
    end
  end

  assign echo_count  = avg_cnt_p1;
  assign count_valid = vld_p1;
`else
  assign echo_count  = res_cnt_p0;
  assign count_valid = vld_p0;
`endif

endmodule

// File: tb/tb_trig_echo_meter.sv
module tb_trig_echo_meter;

  localparam int TRIG_CYCLES    = 250;
  localparam int TIMEOUT_CYCLES = 3000;
  localparam int CNT_W          = 22;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tick_in = 1'b0;
  logic             echo = 1'b0;
  logic             trig;
  logic [CNT_W-1:0] echo_count;
  logic             count_valid;
  logic             timeout;
  logic             missed_tick;
  logic             busy;

  always #5 clk = ~clk;

  trig_echo_meter #(
    .TRIG_CYCLES   (TRIG_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_in    (tick_in),
    .echo       (echo),
    .trig       (trig),
    .echo_count (echo_count),
    .count_valid(count_valid),
    .timeout    (timeout),
    .missed_tick(missed_tick),
    .busy       (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard events: kind 0 = count_valid with value, 1 = timeout, 2 = missed_tick
  typedef struct {
    int kind;
    int val;
  } ev_t;
  ev_t q[$];

  // Reference for the reported count (raw or 4-sample mean)
  int win[4];
  int fill     = 0;
  int last_cnt = 0;

  int   trig_rises = 0;
  int   trig_run   = 0;
  logic trig_prev  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_ev(input int kind, input int val);
    q.push_back('{kind: kind, val: val});
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) win[i] = 0;
    fill     = 0;
    last_cnt = 0;
  endfunction

  function automatic void exp_valid(input int raw);
`ifdef ECHO_AVG_EN
    win[3] = win[2];
    win[2] = win[1];
    win[1] = win[0];
    win[0] = raw;
    if (fill < 4) fill++;
    if (fill == 4) begin
      last_cnt = (win[0] + win[1] + win[2] + win[3]) / 4;
      push_ev(0, last_cnt);
    end
`else
    last_cnt = raw;
    push_ev(0, raw);
`endif
  endfunction

  task automatic check_ev(input int kind, input int val, input string name);
    ev_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected strobe (value %0d), scoreboard empty (t=%0t)", name, val, $time);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || (kind == 0 && e.val != val)) begin
        n_fail++;
        $display("FAIL %s: got kind %0d value %0d, expected kind %0d value %0d (t=%0t)",
                 name, kind, val, e.kind, e.val, $time);
      end
    end
  endtask

  // Monitor: samples on the falling edge, checks every strobe against the
  // scoreboard and every completed trigger pulse against TRIG_CYCLES.
  always @(negedge clk) begin
    if (rst) begin
      trig_run = 0;
    end else begin
      if (trig && !trig_prev) trig_rises++;
      if (trig) begin
        trig_run++;
      end else if (trig_run > 0) begin
        chk("trig_width", trig_run, TRIG_CYCLES);
        trig_run = 0;
      end
      if (missed_tick) check_ev(2, 0, "missed_tick");
      if (count_valid) check_ev(0, int'(echo_count), "count_valid");
      if (timeout)     check_ev(1, 0, "timeout");
    end
    trig_prev = trig;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_trig(input logic lvl, input int bound, input string name);
    int i = 0;
    while (trig !== lvl && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk(name, int'(trig), int'(lvl));
  endtask

  task automatic wait_idle(input int bound, input string name);
    int i = 0;
    while (busy !== 1'b0 && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk(name, int'(busy), 0);
  endtask

  task automatic start_tick();
    tick_in = 1'b1;
    wait_trig(1'b1, 20, "trig_rise");
    cyc(5);
    tick_in = 1'b0;
    wait_trig(1'b0, TRIG_CYCLES + 20, "trig_fall");
  endtask

  task automatic measure(input int width);
    start_tick();
    cyc(50);
    echo = 1'b1;
    cyc(width);
    exp_valid(width);
    echo = 1'b0;
    wait_idle(20, "meas_idle");
    cyc(5);
  endtask

  initial begin
    int prev;
    model_reset();

    // Reset state
    rst = 1'b1;
    cyc(5);
    chk("rst_trig", int'(trig), 0);
    chk("rst_echo_count", int'(echo_count), 0);
    chk("rst_count_valid", int'(count_valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_missed_tick", int'(missed_tick), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    cyc(5);

    // Four widths: raw results, or one mean after the fourth
    measure(100);
    measure(200);
    measure(300);
    measure(402);
`ifdef ECHO_AVG_EN
    chk("avg4_result", int'(echo_count), 250);
`else
    chk("last_raw_result", int'(echo_count), 402);
`endif

    // Single measurement with latency checks: tick->trig 4 cycles, echo fall->valid 3
    tick_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("tick_to_trig_early", int'(trig), 0);
    @(negedge clk);
    chk("tick_to_trig", int'(trig), 1);
    chk("busy_in_trig", int'(busy), 1);
    cyc(5);
    tick_in = 1'b0;
    wait_trig(1'b0, TRIG_CYCLES + 20, "trig_fall");
    cyc(50);
    echo = 1'b1;
    cyc(1000);
    exp_valid(1000);
    echo = 1'b0;
    repeat (3) @(negedge clk);
    chk("echo_to_valid_early", int'(count_valid), 0);
`ifdef ECHO_AVG_EN
    @(negedge clk);
`endif
    @(negedge clk);
    chk("echo_to_valid", int'(count_valid), 1);
    chk("no_timeout", int'(timeout), 0);
`ifndef ECHO_AVG_EN
    chk("width_1000", int'(echo_count), 1000);
`endif
    wait_idle(10, "idle_after_1000");
    cyc(5);

    // No echo at all: timeout in WAIT_HI, result held
    prev = last_cnt;
    start_tick();
    chk("busy_waiting", int'(busy), 1);
    push_ev(1, 0);
    wait_idle(TIMEOUT_CYCLES + 50, "idle_after_wait_timeout");
    chk("hold_after_wait_timeout", int'(echo_count), prev);
    cyc(5);

    // Echo longer than the limit: timeout, then RECOVER until echo falls
    start_tick();
    cyc(10);
    echo = 1'b1;
    push_ev(1, 0);
    cyc(TIMEOUT_CYCLES + 500);
    chk("busy_in_recover", int'(busy), 1);
    echo = 1'b0;
    cyc(6);
    chk("idle_after_recover", int'(busy), 0);
    chk("hold_after_meas_timeout", int'(echo_count), prev);
    cyc(5);

    // Second tick during MEASURE: missed, current result completes
    start_tick();
    cyc(50);
    echo = 1'b1;
    cyc(300);
    push_ev(2, 0);
    tick_in = 1'b1;
    cyc(10);
    tick_in = 1'b0;
    cyc(290);
    exp_valid(600);
    echo = 1'b0;
    wait_idle(20, "idle_after_missed");
    cyc(300);
    chk("no_second_trig", int'(trig), 0);

    // Reset in the middle of TRIG, tick level still high afterwards
    tick_in = 1'b1;
    wait_trig(1'b1, 20, "trig_rise_pre_rst");
    cyc(100);
    rst = 1'b1;
    cyc(1);
    chk("midrst_trig", int'(trig), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_echo_count", int'(echo_count), 0);
    model_reset();
    rst = 1'b0;
    cyc(20);
    chk("held_tick_no_edge", int'(trig), 0);
    chk("held_tick_idle", int'(busy), 0);
    tick_in = 1'b0;
    cyc(5);
    measure(77);

    cyc(10);
    chk("trig_pulse_count", trig_rises, 10);
    chk("scoreboard_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/trig_echo_meter.md
# trig_echo_meter

Ranging front end for the theremin distance sensor. Sits directly downstream of the adjustable frequency divider: each rising edge of the divider's `clk_out` starts one measurement cycle. The block issues a fixed-width trigger pulse to the ultrasonic sensor, measures the width of the returned echo pulse in `clk` cycles, and presents the result with a one-cycle valid strobe to the pitch/volume mapping logic.

## Interface
- `TRIG_CYCLES`, 250: trigger pulse width in `clk` cycles (10 us at 25 MHz).
- `TIMEOUT_CYCLES`, 1000000: limit, in `clk` cycles, for the wait-for-echo phase and, separately, for the echo-high phase (40 ms).
- `CNT_W`, 22: width of `echo_count` and the internal timers; must hold `TIMEOUT_CYCLES`.

- `clk`  in  1  system clock, 25 MHz; one clock domain, all logic on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `tick_in`  in  1  level from the divider `clk_out`; its rising edge requests a measurement.
- `echo`  in  1  sensor echo, asynchronous.
- `trig`  out  1  registered trigger to the sensor.
- `echo_count`  out  CNT_W  last valid echo width in cycles; holds until the next valid result.
- `count_valid`  out  1  one-cycle strobe when `echo_count` updates.
- `timeout`  out  1  one-cycle strobe when a measurement is abandoned.
- `missed_tick`  out  1  one-cycle strobe when a tick edge arrives while busy.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `tick_in` and `echo` each pass through a 2-FF synchronizer (`tick_s`, `echo_s`), followed by a delay register for edge detection. Tick edge: `tick_s & ~tick_d`.
- FSM states: IDLE, TRIG, WAIT_HI, MEASURE, RECOVER.
- IDLE: on a tick edge, go to TRIG and load the timer with 0.
- TRIG: `trig`=1. The timer counts. After exactly `TRIG_CYCLES` cycles in TRIG, go to WAIT_HI and clear the timer.
- WAIT_HI:
  - If `echo_s`=1, go to MEASURE with the counter at 1.
  - Otherwise, when the timer reaches `TIMEOUT_CYCLES`, pulse `timeout` and go to IDLE.
- MEASURE: the counter increments each cycle that `echo_s`=1.
  - If `echo_s`=0, latch the counter into `echo_count`, pulse `count_valid` and go to IDLE.
  - If the counter reaches `TIMEOUT_CYCLES` with `echo_s` still 1, pulse `timeout`, leave `echo_count` unchanged and go to RECOVER.
- RECOVER: wait until `echo_s`=0, then go to IDLE. This prevents a partial re-measurement.
- Result rule: `echo_count` equals the number of consecutive cycles `echo_s` was sampled high.
- `missed_tick`: asserted for any tick edge while the FSM is not in IDLE. That tick is dropped and is not queued.
- Echo already high when WAIT_HI is entered: measurement starts immediately; this is accepted behaviour.

## Timing
- Reset values: `trig`=0, `echo_count`=0, `count_valid`=0, `timeout`=0, `missed_tick`=0, `busy`=0, FSM=IDLE, synchronizer and edge registers=0.
- Reset asserted mid-operation: the next cycle is IDLE with all outputs at their reset values. A `tick_s` level that is still high after reset does not produce an edge until it falls and rises again.
- `tick_in` rise to `trig` high: 4 cycles (2 synchronizer, 1 edge detect, 1 state register).
- `trig` is high for exactly `TRIG_CYCLES` consecutive cycles.
- `echo` fall to `count_valid`: 3 cycles. `echo_count` is valid in the same cycle as `count_valid`.
- A tick edge detected in the same cycle the FSM returns to IDLE counts as missed. Only a tick edge seen while in IDLE starts a measurement.
- Timeout in WAIT_HI: `timeout` pulses `TRIG_CYCLES + TIMEOUT_CYCLES` cycles after TRIG entry, with ±1 cycle of state-entry overhead.

## Configuration
- `ECHO_AVG_EN` defined:
  - `echo_count` is the mean of the last 4 valid raw widths, computed as (sum of 4) >> 2, truncated. The sum register is `CNT_W+2` bits wide.
  - `count_valid` is suppressed until 4 valid results have been collected since reset.
  - Timeouts do not enter the window.
  - The output strobe is one cycle later than the raw path.
- `ECHO_AVG_EN` undefined: raw width output as described in Operation; no averaging hardware.

## Test plan
- Reset, then one tick edge; echo driven high 50 cycles after `trig` falls, held 1000 cycles -> `trig` high exactly 250 cycles, `echo_count`=1000, `count_valid` one cycle, `timeout`=0.
- Tick edge with echo never rising -> `timeout` pulses once; `echo_count` keeps its prior value; `busy` falls.
- Echo held high for more than `TIMEOUT_CYCLES` -> `timeout` pulse, FSM stays in RECOVER until echo falls, no `count_valid`.
- Second tick edge during MEASURE -> `missed_tick` pulse, the current result completes normally, no second `trig`.
- `rst` asserted in the middle of TRIG -> `trig`=0 and `busy`=0 the next cycle; a new tick edge restarts with a full 250-cycle trigger.
- With `ECHO_AVG_EN`, widths 100, 200, 300, 402 -> first `count_valid` only after the 4th result, `echo_count`=250.
